// File: rtl/status_led_pio.sv
// -----------------------------------------------------------------------------
// status_led_pio
// Avalon-MM slave that drives LED_WIDTH LED outputs with atomic set/clear,
// per-bit blink mode and a programmable blink rate, and watches STAT_WIDTH
// asynchronous status inputs. Rising edges on the status inputs are latched
// into sticky EDGE bits that raise a maskable level interrupt.
//
// Ports:
//   clk_clk                            system clock
//   reset_reset                        synchronous reset, active-high
//   avs_address/read/write/writedata   Avalon-MM slave request (no waitrequest)
//   avs_readdata                       registered read data, 1-cycle latency
//   irq                                registered level interrupt
//   stat_in                            asynchronous status inputs
//   led_pio_external_connection_export registered LED drive
//
// Word map: 0 DATA, 1 SET, 2 CLR, 3 MODE, 4 BLINK_DIV, 5 STAT, 6 EDGE (W1C),
//           7 IRQ_MASK. Unused bits read as 0.
// -----------------------------------------------------------------------------
module status_led_pio #(
  parameter int LED_WIDTH  = 8,
  parameter int STAT_WIDTH = 3,
  parameter int PRESCALE   = 50000,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic [2:0]            avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [31:0]           avs_writedata,
  output logic [31:0]           avs_readdata,
  output logic                  irq,
  input  logic [STAT_WIDTH-1:0] stat_in,
  output logic [LED_WIDTH-1:0]  led_pio_external_connection_export
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_SET  = 3'd1;
  localparam logic [2:0] A_CLR  = 3'd2;
  localparam logic [2:0] A_MODE = 3'd3;
  localparam logic [2:0] A_DIV  = 3'd4;
  localparam logic [2:0] A_STAT = 3'd5;
  localparam logic [2:0] A_EDGE = 3'd6;
  localparam logic [2:0] A_MASK = 3'd7;

  logic [LED_WIDTH-1:0]  data_q, data_d;
  logic [LED_WIDTH-1:0]  mode_q, mode_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [STAT_WIDTH-1:0] mask_q, mask_d;
  logic [STAT_WIDTH-1:0] edge_q, edge_d;
  logic [STAT_WIDTH-1:0] sync1_q, sync1_d;
  logic [STAT_WIDTH-1:0] stat_s_q, stat_s_d;
  logic [STAT_WIDTH-1:0] stat_prev_q, stat_prev_d;
  logic [PW-1:0]         pre_q, pre_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  irq_q, irq_d;
  logic [LED_WIDTH-1:0]  led_q, led_d;

  logic                  tick;
  logic [STAT_WIDTH-1:0] rise;
  logic [31:0]           rd_mux;

  // Not every write-data bit lands in a register for every width choice;
  // folding the bus here keeps the whole port visibly consumed.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  // Register-file updates: bus writes, sticky edge capture, synchroniser.
  always_comb begin
    data_d      = data_q;
    mode_d      = mode_q;
    div_d       = div_q;
    mask_d      = mask_q;
    sync1_d     = stat_in;
    stat_s_d    = sync1_q;
    stat_prev_d = stat_s_q;
    rise        = stat_s_q & ~stat_prev_q;
    edge_d      = edge_q;
    if (avs_write) begin
      case (avs_address)
        A_DATA:  data_d = avs_writedata[LED_WIDTH-1:0];
        A_SET:   data_d = data_q | avs_writedata[LED_WIDTH-1:0];
        A_CLR:   data_d = data_q & ~avs_writedata[LED_WIDTH-1:0];
        A_MODE:  mode_d = avs_writedata[LED_WIDTH-1:0];
        A_DIV:   div_d  = avs_writedata[DIV_WIDTH-1:0];
        A_EDGE:  edge_d = edge_q & ~avs_writedata[STAT_WIDTH-1:0];
        A_MASK:  mask_d = avs_writedata[STAT_WIDTH-1:0];
        default: ;
      endcase
    end
    // A new edge overrides a clear landing in the same cycle.
    edge_d = edge_d | rise;
  end

  // Blink timebase: prescaler tick drives a half-period counter and phase.
  always_comb begin
    tick    = (pre_q == PW'(PRESCALE - 1));
    pre_d   = tick ? '0 : pre_q + 1'b1;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (div_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (tick) begin
      if (cnt_q == div_q - 1'b1) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (avs_write && avs_address == A_DIV) begin
      cnt_d = '0;
    end
  end

  // Read mux (pre-write values), interrupt and LED output next-state.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      A_DATA, A_SET, A_CLR: rd_mux[LED_WIDTH-1:0]  = data_q;
      A_MODE:               rd_mux[LED_WIDTH-1:0]  = mode_q;
      A_DIV:                rd_mux[DIV_WIDTH-1:0]  = div_q;
      A_STAT:               rd_mux[STAT_WIDTH-1:0] = stat_s_q;
      A_EDGE:               rd_mux[STAT_WIDTH-1:0] = edge_q;
      A_MASK:               rd_mux[STAT_WIDTH-1:0] = mask_q;
      default:              rd_mux = '0;
    endcase
    rdata_d = avs_read ? rd_mux : rdata_q;
    irq_d   = |(edge_q & mask_q);
    led_d   = data_q & (~mode_q | {LED_WIDTH{phase_q}});
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      data_q      <= '0;
      mode_q      <= '0;
      div_q       <= '0;
      mask_q      <= '0;
      edge_q      <= '0;
      sync1_q     <= '0;
      stat_s_q    <= '0;
      stat_prev_q <= '0;
      pre_q       <= '0;
      cnt_q       <= '0;
      phase_q     <= 1'b1;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
      led_q       <= '0;
    end else begin
      data_q      <= data_d;
      mode_q      <= mode_d;
      div_q       <= div_d;
      mask_q      <= mask_d;
      edge_q      <= edge_d;
      sync1_q     <= sync1_d;
      stat_s_q    <= stat_s_d;
      stat_prev_q <= stat_prev_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
      led_q       <= led_d;
    end
  end

  assign avs_readdata                       = rdata_q;
  assign irq                                = irq_q;
  assign led_pio_external_connection_export = led_q;

endmodule

// File: tb/tb_status_led_pio.sv
// -----------------------------------------------------------------------------
// tb_status_led_pio
// Directed, self-checking bench for status_led_pio (PRESCALE shortened to 4).
// Register read/write behaviour is driven from a vector table; blink timing,
// edge/irq latency and same-cycle corner cases use hand-written sequences.
// -----------------------------------------------------------------------------
module tb_status_led_pio;

  logic        clk = 1'b0;
  logic        reset_reset;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;
  logic [2:0]  stat_in;
  logic [7:0]  led;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_read;
  } vec_t;

  vec_t vecs[12];

  status_led_pio #(
    .LED_WIDTH(8), .STAT_WIDTH(3), .PRESCALE(4), .DIV_WIDTH(16)
  ) dut (
    .clk_clk(clk),
    .reset_reset(reset_reset),
    .avs_address(avs_address),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata),
    .irq(irq),
    .stat_in(stat_in),
    .led_pio_external_connection_export(led)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Single write; returns 1 ns after the clock edge that performs it.
  task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_write     = 1'b1;
    avs_address   = a;
    avs_writedata = d;
    @(posedge clk);
    #1;
    avs_write = 1'b0;
  endtask

  // Single read; the value is captured at the edge and sampled 1 ns later.
  task automatic busRead(input logic [2:0] a, output logic [31:0] v);
    @(negedge clk);
    avs_read    = 1'b1;
    avs_address = a;
    @(posedge clk);
    #1;
    avs_read = 1'b0;
    v = avs_readdata;
  endtask

  task automatic readWrite(input logic [2:0] a, input logic [31:0] d, output logic [31:0] v);
    @(negedge clk);
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    avs_address   = a;
    avs_writedata = d;
    @(posedge clk);
    #1;
    avs_read  = 1'b0;
    avs_write = 1'b0;
    v = avs_readdata;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  model;
    logic [7:0]  prev_led;
    logic        prev_bit;
    int          trans[3];
    int          n_trans;
    int          bad;

    vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_00FF};
    vecs[1]  = '{3'd3, 32'h1234_5678, 32'h0000_0078};
    vecs[2]  = '{3'd4, 32'hABCD_1234, 32'h0000_1234};
    vecs[3]  = '{3'd7, 32'h0000_0005, 32'h0000_0005};
    vecs[4]  = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0007};
    vecs[5]  = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6]  = '{3'd1, 32'h0000_0000, 32'h0000_00FF};
    vecs[7]  = '{3'd2, 32'h0000_00F0, 32'h0000_000F};
    vecs[8]  = '{3'd0, 32'h0000_0000, 32'h0000_0000};
    vecs[9]  = '{3'd3, 32'h0000_0000, 32'h0000_0000};
    vecs[10] = '{3'd7, 32'h0000_0000, 32'h0000_0000};
    vecs[11] = '{3'd4, 32'h0000_0000, 32'h0000_0000};

    reset_reset   = 1'b1;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    stat_in       = 3'b111;

    // Reset held three cycles with all status inputs high.
    waitCycles(3);
    checkOutput("reset_led", 32'(led), 32'h0);
    checkOutput("reset_irq", 32'(irq), 32'h0);
    checkOutput("reset_readdata", avs_readdata, 32'h0);
    @(negedge clk);
    reset_reset = 1'b0;

    busRead(3'd6, v); checkOutput("rst_edge", v, 32'h0);
    for (int a = 0; a < 5; a++) begin
      busRead(3'(a), v);
      checkOutput($sformatf("rst_reg%0d", a), v, 32'h0);
    end
    busRead(3'd7, v); checkOutput("rst_mask", v, 32'h0);
    busRead(3'd5, v); checkOutput("rst_stat", v, 32'h7);
    checkOutput("rst_irq_after", 32'(irq), 32'h0);

    // Quiet the status inputs and drop the edges seen after reset.
    @(negedge clk);
    stat_in = 3'b000;
    waitCycles(4);
    applyStimulus(3'd6, 32'h7);
    busRead(3'd6, v); checkOutput("edge_cleared", v, 32'h0);

    // Register access table.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].addr, vecs[i].wdata);
      busRead(vecs[i].addr, v);
      checkOutput($sformatf("vec%0d_a%0d", i, vecs[i].addr), v, vecs[i].exp_read);
    end

    // DATA / SET / CLR with LED latency.
    model = 8'h00;
    prev_led = model; model = 8'hA5;
    applyStimulus(3'd0, 32'hA5);
    checkOutput("led_data_old", 32'(led), 32'(prev_led));
    waitCycles(1);
    checkOutput("led_data", 32'(led), 32'(model));
    prev_led = model; model = model | 8'h0F;
    applyStimulus(3'd1, 32'h0F);
    checkOutput("led_set_old", 32'(led), 32'(prev_led));
    waitCycles(1);
    checkOutput("led_set", 32'(led), 32'(model));
    prev_led = model; model = model & ~8'h81;
    applyStimulus(3'd2, 32'h81);
    checkOutput("led_clr_old", 32'(led), 32'(prev_led));
    waitCycles(1);
    checkOutput("led_clr", 32'(led), 32'(model));
    busRead(3'd0, v); checkOutput("data_read", v, 32'(model));
    busRead(3'd2, v); checkOutput("clr_read", v, 32'(model));

    // Blink: PRESCALE 4, BLINK_DIV 2 -> led[0] half-period of 8 cycles.
    applyStimulus(3'd0, 32'h01);
    applyStimulus(3'd3, 32'h01);
    applyStimulus(3'd4, 32'h02);
    n_trans  = 0;
    prev_bit = led[0];
    for (int c = 0; c < 60 && n_trans < 3; c++) begin
      waitCycles(1);
      if (led[0] !== prev_bit) begin
        trans[n_trans] = c;
        n_trans++;
      end
      prev_bit = led[0];
    end
    checkOutput("blink_transitions", 32'(n_trans), 32'd3);
    if (n_trans == 3) begin
      checkOutput("blink_period1", 32'(trans[1] - trans[0]), 32'd8);
      checkOutput("blink_period2", 32'(trans[2] - trans[1]), 32'd8);
    end
    applyStimulus(3'd4, 32'h0);
    waitCycles(3);
    bad = 0;
    for (int c = 0; c < 16; c++) begin
      if (led[0] !== 1'b1) bad++;
      waitCycles(1);
    end
    checkOutput("blink_div0_steady", 32'(bad), 32'd0);
    applyStimulus(3'd3, 32'h0);
    applyStimulus(3'd0, 32'h0);

    // Edge capture latency and interrupt.
    applyStimulus(3'd7, 32'h1);
    @(negedge clk);
    stat_in = 3'b001;
    @(posedge clk);
    @(posedge clk);
    busRead(3'd6, v); checkOutput("edge_before", v, 32'h0);
    checkOutput("irq_before", 32'(irq), 32'h0);
    busRead(3'd6, v); checkOutput("edge_set", v, 32'h1);
    checkOutput("irq_set", 32'(irq), 32'h1);
    applyStimulus(3'd6, 32'h1);
    checkOutput("irq_hold", 32'(irq), 32'h1);
    waitCycles(1);
    checkOutput("irq_cleared", 32'(irq), 32'h0);
    busRead(3'd6, v); checkOutput("edge_w1c", v, 32'h0);

    // Edge and W1C on the same bit in the same cycle: the edge wins.
    @(negedge clk);
    stat_in = 3'b011;
    @(posedge clk);
    @(posedge clk);
    applyStimulus(3'd6, 32'h2);
    busRead(3'd6, v); checkOutput("edge_set_wins", v, 32'h2);
    checkOutput("irq_unmasked", 32'(irq), 32'h0);
    applyStimulus(3'd6, 32'h2);
    busRead(3'd6, v); checkOutput("edge_w1c_bit1", v, 32'h0);

    // Same-cycle read and write returns the old value.
    applyStimulus(3'd0, 32'h11);
    readWrite(3'd0, 32'h22, v); checkOutput("rw_old", v, 32'h11);
    busRead(3'd0, v); checkOutput("rw_new", v, 32'h22);

    // Reset mid-operation.
    @(negedge clk);
    reset_reset = 1'b1;
    waitCycles(1);
    checkOutput("midreset_readdata", avs_readdata, 32'h0);
    @(negedge clk);
    reset_reset = 1'b0;
    busRead(3'd0, v); checkOutput("midreset_data", v, 32'h0);
    busRead(3'd7, v); checkOutput("midreset_mask", v, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
